// File: rtl/siggen_mode_ctrl.sv
// Signal generator front-panel controller: debounces buttons and switches, and sequences
// reconfiguration of the waveform datapath as disable -> drain -> load config -> enable.

module siggen_btn_db #(
    parameter int DEBOUNCE_CYCLES = 1_250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);
    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized level disagrees with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module siggen_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_250_000,
    parameter int BASE_DIV        = 125_000,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sw,
    input  logic [3:0]  btn,
    input  logic        gen_busy,
    input  logic        cfg_ready,
    output logic        cfg_valid,
    output logic [1:0]  wave_sel,
    output logic [29:0] half_period,
    output logic        gen_en,
    output logic [3:0]  mode_led,
    output logic        drain_fault
);
    localparam int            NUM_BTN   = 4;
    localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam int            TW        = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0] DRAIN_MAX = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [29:0]   BASE      = 30'(BASE_DIV);
    localparam logic [1:0]    WAVE_OFF  = 2'b11;

    typedef enum logic [1:0] {S_OFF, S_LOAD, S_RUN, S_DRAIN} state_t;
    typedef struct packed {
        logic [1:0]  wave;
        logic [29:0] half;
    } cfg_t;

    state_t               state, state_nxt;
    cfg_t                 cfg_q;
    logic [NUM_BTN-1:0]   btn_stb, btn_stb_d, press;
    logic [7:0]           sw_s1, sw_s2, sw_latched;
    logic [CW-1:0]        sw_cnt;
    logic                 sw_evt;
    logic [1:0]           pending_sel, pend_nxt, ev_idx, ev_tgt;
    logic                 pending_dirty, dirty_nxt;
    logic                 ev_press, ev_any, load_go, off_go, timeout_hit;
    logic [TW-1:0]        drain_cnt;
    logic [8:0]           sw_p1;
    logic [29:0]          half_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            siggen_btn_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk    (clk),
                .rst_n  (rst_n),
                .raw    (btn[gi]),
                .stable (btn_stb[gi])
            );
        end
    endgenerate

    // Shared switch counter restarts whenever the word is still moving or matches the latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            sw_cnt     <= '0;
            sw_latched <= '0;
            sw_evt     <= 1'b0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            sw_evt <= 1'b0;
            if (sw_s2 == sw_latched || sw_s1 != sw_s2) begin
                sw_cnt <= '0;
            end else if (sw_cnt == CNT_MAX) begin
                sw_latched <= sw_s2;
                sw_evt     <= 1'b1;
                sw_cnt     <= '0;
            end else begin
                sw_cnt <= sw_cnt + 1'b1;
            end
        end
    end

    assign press    = btn_stb & ~btn_stb_d;
    assign ev_press = |press;
    assign ev_any   = ev_press | sw_evt;
    assign ev_tgt   = ev_press ? ev_idx : pending_sel;
    assign sw_p1    = {1'b0, sw_latched} + 9'd1;
    assign half_nxt = {21'd0, sw_p1} * BASE;

    always_comb begin
        ev_idx = 2'd0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press[i]) ev_idx = 2'(i);
        end
    end

    always_comb begin
        state_nxt   = state;
        pend_nxt    = pending_sel;
        dirty_nxt   = pending_dirty;
        load_go     = 1'b0;
        off_go      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_OFF: begin
                if (ev_press && ev_idx != WAVE_OFF) begin
                    pend_nxt  = ev_idx;
                    load_go   = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ev_any) begin
                    pend_nxt  = ev_tgt;
                    dirty_nxt = 1'b1;
                end
                if (cfg_ready) state_nxt = dirty_nxt ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                // Re-pressing the running wave is a no-op unless the period moved too.
                if (ev_any && !(ev_press && ev_idx == cfg_q.wave && !sw_evt)) begin
                    pend_nxt  = ev_tgt;
                    dirty_nxt = 1'b1;
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ev_any) begin
                    pend_nxt  = ev_tgt;
                    dirty_nxt = 1'b1;
                end
                if (!gen_busy || drain_cnt == DRAIN_MAX) begin
                    timeout_hit = gen_busy;
                    if (pend_nxt == WAVE_OFF) begin
                        state_nxt = S_OFF;
                        off_go    = 1'b1;
                    end else begin
                        state_nxt = S_LOAD;
                        load_go   = 1'b1;
                    end
                end
            end
            default: state_nxt = S_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_OFF;
            cfg_q         <= '{wave: WAVE_OFF, half: BASE};
            pending_sel   <= WAVE_OFF;
            pending_dirty <= 1'b0;
            drain_cnt     <= '0;
            drain_fault   <= 1'b0;
            btn_stb_d     <= '0;
        end else begin
            state         <= state_nxt;
            btn_stb_d     <= btn_stb;
            pending_sel   <= pend_nxt;
            pending_dirty <= dirty_nxt;
            drain_cnt     <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (timeout_hit) drain_fault <= 1'b1;
            // Config is captured only on LOAD entry so it stays frozen through the handshake.
            if (load_go) begin
                cfg_q         <= '{wave: pend_nxt, half: half_nxt};
                pending_dirty <= 1'b0;
            end else if (off_go) begin
                cfg_q.wave    <= WAVE_OFF;
                pending_dirty <= 1'b0;
            end
        end
    end

    assign cfg_valid   = (state == S_LOAD);
    assign gen_en      = (state == S_RUN);
    assign wave_sel    = cfg_q.wave;
    assign half_period = cfg_q.half;
    assign mode_led    = 4'b0001 << cfg_q.wave;
endmodule

// File: tb/tb_siggen_mode_ctrl.sv
// Bench for siggen_mode_ctrl: directed panel scenarios with literal checks, then random
// stimulus compared every cycle against a behavioural model of the panel rules.
module tb_siggen_mode_ctrl;
    localparam int DEB  = 4;
    localparam int BASE = 10;
    localparam int TO   = 8;
    localparam int OFFP = 0, LOADP = 1, RUNP = 2, DRAINP = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic        gen_busy, cfg_ready;
    logic        cfg_valid, gen_en, drain_fault;
    logic [1:0]  wave_sel;
    logic [29:0] half_period;
    logic [3:0]  mode_led;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    siggen_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .BASE_DIV(BASE), .DRAIN_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .gen_busy(gen_busy),
        .cfg_ready(cfg_ready), .cfg_valid(cfg_valid), .wave_sel(wave_sel),
        .half_period(half_period), .gen_en(gen_en), .mode_led(mode_led),
        .drain_fault(drain_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase, m_half, m_dcyc;
    logic [1:0] m_wave, m_pend;
    logic       m_dirty, m_fault, m_evs;
    logic [7:0] m_latched;
    logic [3:0] m_stable, m_evp;
    logic [3:0] hb [6];   // raw button samples, hb[k] taken k edges ago
    logic [7:0] hs [6];

    task automatic m_reset();
        m_phase = OFFP; m_wave = 2'd3; m_pend = 2'd3; m_half = BASE;
        m_dirty = 1'b0; m_fault = 1'b0; m_dcyc = 0;
        m_latched = '0; m_stable = '0; m_evp = '0; m_evs = 1'b0;
        for (int k = 0; k < 6; k++) begin hb[k] = '0; hs[k] = '0; end
    endtask

    task automatic m_enter_load();
        m_wave  = m_pend;
        m_half  = (int'(m_latched) + 1) * BASE;
        m_dirty = 1'b0;
        m_phase = LOADP;
    endtask

    task automatic m_step();
        int         pidx;
        logic [1:0] tgt;
        bit         any, all_diff, all_eq;
        pidx = -1;
        for (int i = 0; i < 4; i++) if (m_evp[i] && pidx < 0) pidx = i;
        tgt = (pidx >= 0) ? 2'(pidx) : m_pend;
        any = (pidx >= 0) || m_evs;
        case (m_phase)
            OFFP: if (pidx >= 0 && pidx < 3) begin m_pend = tgt; m_enter_load(); end
            RUNP: if (any && !(pidx == int'(m_wave) && !m_evs)) begin
                m_pend = tgt; m_dirty = 1'b1; m_phase = DRAINP; m_dcyc = 0;
            end
            LOADP: begin
                if (any) begin m_pend = tgt; m_dirty = 1'b1; end
                if (cfg_ready) begin
                    if (m_dirty) begin m_phase = DRAINP; m_dcyc = 0; end
                    else m_phase = RUNP;
                end
            end
            default: begin
                if (any) begin m_pend = tgt; m_dirty = 1'b1; end
                m_dcyc++;
                if (!gen_busy || m_dcyc == TO) begin
                    if (gen_busy) m_fault = 1'b1;
                    if (m_pend == 2'd3) begin m_phase = OFFP; m_wave = 2'd3; m_dirty = 1'b0; end
                    else m_enter_load();
                end
            end
        endcase
        for (int k = 5; k > 0; k--) begin hb[k] = hb[k-1]; hs[k] = hs[k-1]; end
        hb[0] = btn;
        hs[0] = sw;
        // A button level is accepted after 4 consecutive synchronized samples that differ.
        m_evp = '0;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= 5; k++) if (hb[k][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) begin m_stable[i] = ~m_stable[i]; m_evp[i] = m_stable[i]; end
        end
        all_eq = 1'b1;
        for (int k = 2; k <= 5; k++) if (hs[k] != hs[1]) all_eq = 1'b0;
        m_evs = all_eq && (hs[1] != m_latched);
        if (m_evs) m_latched = hs[1];
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cfg_valid", cfg_valid, m_phase == LOADP);
            chk("gen_en", gen_en, m_phase == RUNP);
            chk("wave_sel", wave_sel, m_wave);
            chk("half_period", half_period, m_half);
            chk("mode_led", mode_led, 4'b0001 << m_wave);
            chk("drain_fault", drain_fault, m_fault);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int vcnt;
        rst_n = 1'b0; sw = 8'd3; btn = '0; gen_busy = 1'b0; cfg_ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        chk("rst_wave", wave_sel, 2'b11);
        chk("rst_half", half_period, 10);
        chk("rst_led", mode_led, 4'b1000);
        chk("rst_valid", cfg_valid, 0);
        tick(10);

        btn = 4'b0001; tick(6); btn = '0;
        vcnt = 0;
        repeat (12) begin tick(1); if (cfg_valid) vcnt++; end
        chk("sq_valid_cycles", vcnt, 1);
        chk("sq_wave", wave_sel, 2'b00);
        chk("sq_half", half_period, 40);
        chk("sq_gen_en", gen_en, 1);
        chk("sq_led", mode_led, 4'b0001);

        btn = 4'b0010; tick(2); btn = '0; tick(8);
        chk("glitch_wave", wave_sel, 2'b00);
        chk("glitch_gen_en", gen_en, 1);

        gen_busy = 1'b1; btn = 4'b0010; tick(6); btn = '0; tick(3);
        chk("drain_gen_en", gen_en, 0);
        chk("drain_valid", cfg_valid, 0);
        cfg_ready = 1'b0; gen_busy = 1'b0; tick(3);
        chk("saw_valid", cfg_valid, 1);
        chk("saw_wave", wave_sel, 2'b01);

        btn = 4'b0100; tick(6); btn = '0; tick(4);
        chk("frozen_wave", wave_sel, 2'b01);
        chk("frozen_valid", cfg_valid, 1);
        cfg_ready = 1'b1; tick(8);
        chk("tri_wave", wave_sel, 2'b10);
        chk("tri_gen_en", gen_en, 1);

        sw = 8'd255; tick(2); sw = 8'd3; tick(10);
        chk("bounce_half", half_period, 40);
        chk("bounce_gen_en", gen_en, 1);
        sw = 8'd255; tick(15);
        chk("sw255_half", half_period, 2560);
        chk("sw255_wave", wave_sel, 2'b10);
        chk("sw255_gen_en", gen_en, 1);

        chk("no_fault_yet", drain_fault, 0);
        gen_busy = 1'b1; btn = 4'b0001; tick(6); btn = '0; tick(14);
        chk("timeout_fault", drain_fault, 1);
        chk("timeout_wave", wave_sel, 2'b00);
        gen_busy = 1'b0; tick(4);
        chk("fault_sticky", drain_fault, 1);

        btn = 4'b1000; tick(6); btn = '0; tick(6);
        chk("off_wave", wave_sel, 2'b11);
        chk("off_led", mode_led, 4'b1000);
        chk("off_gen_en", gen_en, 0);

        cfg_ready = 1'b0; btn = 4'b0010; tick(6); btn = '0; tick(3);
        chk("pre_rst_valid", cfg_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", cfg_valid, 0);
        chk("async_rst_wave", wave_sel, 2'b11);
        chk("async_rst_fault", drain_fault, 0);
        chk("async_rst_half", half_period, 10);
        tick(2);
        rst_n = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) btn = btn ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) sw = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 3) == 0) gen_busy = ~gen_busy;
            cfg_ready = ($urandom_range(0, 2) != 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
